// File: rtl/z_mon_pkg.sv
// z_mon_pkg: shared definitions for the z_stream_monitor block.
//   state_t  : detector FSM state encoding (3-bit).
//   PATTERN  : the serial pattern being detected, oldest bit first (MSB).
//   HIST_W   : width of the sample history window.
package z_mon_pkg;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1011;
  localparam int         HIST_W  = 8;

endpackage

// File: rtl/z_stream_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and
// asynchronous active-high reset. Clear has priority over increment.
//   i_clk  : clock
//   i_rst  : async reset, active high
//   i_inc  : increment by one, holds at all-ones
//   i_clr  : synchronous clear to zero
//   o_cnt  : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/z_stream_monitor.sv
// z_stream_monitor: watches the serial Z output of an upstream stage and
// collects statistics on the samples qualified by EN.
//   CLK     : clock, rising edge
//   RST     : async reset, active high
//   Z       : serial data in
//   EN      : sample qualifier
//   CLR     : synchronous clear of all statistics and the FSM (beats EN)
//   HIT     : one-cycle pulse after the sample completing 1011 (overlapping)
//   HIT_CNT : saturating count of detections
//   RUN_MAX : longest run of consecutive sampled ones, saturating
//   HIST    : last 8 sampled Z values, bit 0 newest
module z_stream_monitor
  import z_mon_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Z,
  input  logic              EN,
  input  logic              CLR,
  output logic              HIT,
  output logic [CNT_W-1:0]  HIT_CNT,
  output logic [RUN_W-1:0]  RUN_MAX,
  output logic [HIST_W-1:0] HIST
);

  state_t              r_state;
  logic                r_hit;
  logic [RUN_W-1:0]    r_run_max;
  logic [HIST_W-1:0]   r_hist;

  logic                w_sample;
  logic                w_detect;
  logic [RUN_W-1:0]    w_run;
  logic [RUN_W-1:0]    w_run_next;

  assign w_sample = EN & ~CLR;
  assign w_detect = w_sample & Z & (r_state == S101);

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_detect),
    .i_clr (CLR),
    .o_cnt (HIT_CNT)
  );

  // A sampled zero ends the run, so it clears the run counter.
  sat_counter #(.W(RUN_W)) u_run_cnt (
    .i_clk (CLK),
    .i_rst (RST),
    .i_inc (w_sample & Z),
    .i_clr (CLR | (w_sample & ~Z)),
    .o_cnt (w_run)
  );

  // Value the run counter takes on a sampled one; lets RUN_MAX track it
  // on the same edge instead of one cycle later.
  assign w_run_next = (&w_run) ? w_run : w_run + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S0;
      r_hit     <= 1'b0;
      r_run_max <= '0;
      r_hist    <= '0;
    end else if (CLR) begin
      r_state   <= S0;
      r_hit     <= 1'b0;
      r_run_max <= '0;
      r_hist    <= '0;
    end else begin
      r_hit <= w_detect;
      if (EN) begin
        r_hist <= {r_hist[HIST_W-2:0], Z};
        if (Z && (w_run_next > r_run_max)) begin
          r_run_max <= w_run_next;
        end
        case (r_state)
          S0:      r_state <= Z ? S1    : S0;
          S1:      r_state <= Z ? S1    : S10;
          S10:     r_state <= Z ? S101  : S0;
          S101:    r_state <= Z ? S1011 : S10;
          S1011:   r_state <= Z ? S1    : S10;
          default: r_state <= S0;
        endcase
      end
    end
  end

  assign HIT     = r_hit;
  assign RUN_MAX = r_run_max;
  assign HIST    = r_hist;

endmodule

// File: tb/tb_z_stream_monitor.sv
module tb_z_stream_monitor;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Z   = 1'b0;
  logic       EN  = 1'b0;
  logic       CLR = 1'b0;

  logic       hit_a, hit_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [3:0] rmax_a, rmax_b;
  logic [7:0] hist_a, hist_b;

  z_stream_monitor u_dut_a (
    .CLK(CLK), .RST(RST), .Z(Z), .EN(EN), .CLR(CLR),
    .HIT(hit_a), .HIT_CNT(cnt_a), .RUN_MAX(rmax_a), .HIST(hist_a)
  );

  z_stream_monitor #(.CNT_W(2), .RUN_W(4)) u_dut_b (
    .CLK(CLK), .RST(RST), .Z(Z), .EN(EN), .CLR(CLR),
    .HIT(hit_b), .HIT_CNT(cnt_b), .RUN_MAX(rmax_b), .HIST(hist_b)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int hit;
    int cnt8;
    int cnt2;
    int rmax;
    int hist;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: samples since the last clear/reset, as plain numbers.
  int m_bits   = 0;
  int m_nsamp  = 0;
  int m_run    = 0;
  int m_rmax   = 0;
  int m_hits   = 0;
  int m_total  = 0;
  int m_hit    = 0;
  int dut_hits = 0;
  bit mon_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    m_bits  = 0;
    m_nsamp = 0;
    m_run   = 0;
    m_rmax  = 0;
    m_hits  = 0;
    m_hit   = 0;
  endtask

  task automatic model_step(input bit z, input bit en, input bit clr);
    if (clr) begin
      model_clear();
    end else if (en) begin
      m_bits  = ((m_bits << 1) | int'(z)) & 255;
      m_nsamp = min_i(m_nsamp + 1, 100);
      m_hit   = (m_nsamp >= 4 && (m_bits & 15) == 11) ? 1 : 0;
      if (m_hit != 0) begin
        m_hits++;
        m_total++;
      end
      m_run  = z ? m_run + 1 : 0;
      if (min_i(m_run, 15) > m_rmax) m_rmax = min_i(m_run, 15);
    end else begin
      m_hit = 0;
    end
  endtask

  task automatic drive(input bit z, input bit en, input bit clr, input bit rst_pulse);
    exp_t e;
    @(negedge CLK);
    if (rst_pulse) begin
      #1 RST = 1'b1;
      #1;
      chk("rst_async_hit",  int'(hit_a),  0);
      chk("rst_async_cnt",  int'(cnt_a),  0);
      chk("rst_async_rmax", int'(rmax_a), 0);
      chk("rst_async_hist", int'(hist_a), 0);
      chk("rst_async_cnt2", int'(cnt_b),  0);
      model_clear();
      #1 RST = 1'b0;
    end
    Z = z; EN = en; CLR = clr;
    model_step(z, en, clr);
    e.hit  = m_hit;
    e.cnt8 = min_i(m_hits, 255);
    e.cnt2 = min_i(m_hits, 3);
    e.rmax = m_rmax;
    e.hist = m_bits;
    q.push_back(e);
  endtask

  task automatic drive_seq(input logic [31:0] bits, input int len);
    logic [31:0] b;
    b = bits;
    for (int i = len - 1; i >= 0; i--) drive(b[i], 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: every edge following a driven cycle produces one scoreboard entry.
  initial begin
    exp_t e;
    while (!mon_done) begin
      @(posedge CLK);
      #1;
      if (hit_a) dut_hits++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("hit",      int'(hit_a),  e.hit);
        chk("hit_cnt",  int'(cnt_a),  e.cnt8);
        chk("run_max",  int'(rmax_a), e.rmax);
        chk("hist",     int'(hist_a), e.hist);
        chk("hit_w2",   int'(hit_b),  e.hit);
        chk("hit_cnt2", int'(cnt_b),  e.cnt2);
      end
    end
  end

  initial begin
    #3;
    chk("reset_hit",  int'(hit_a),  0);
    chk("reset_cnt",  int'(cnt_a),  0);
    chk("reset_rmax", int'(rmax_a), 0);
    chk("reset_hist", int'(hist_a), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // 1,0,1,1,0,1,1: hits after samples 4 and 7
    drive_seq(32'b1011011, 7);
    // idle
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    // clear, then 1,1,1,0,1,1: run max 3
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive_seq(32'b111011, 6);
    // clear, 1,0,1, stall 5 cycles with Z toggling, then resume with 1
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive_seq(32'b101, 3);
    for (int i = 0; i < 5; i++) drive(i[0], 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    // hit right before a stall: pulse must not stretch
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive_seq(32'b1011, 4);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
    // 5 overlapping hits: narrow counter saturates at 3
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive_seq(32'b1011011011011011, 16);
    // async reset after 1,0,1; following 1 must not hit
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive_seq(32'b101, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    // clear on the completing 1 of 101 -> 1011
    drive_seq(32'b101, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    // long run of ones: run counter saturation
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    // many hits: wide counter saturation at 255
    for (int i = 0; i < 900; i++) drive((i % 3) != 1, 1'b1, 1'b0, 1'b0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 80,
            $urandom_range(0, 199) == 0,
            $urandom_range(0, 299) == 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    mon_done = 1;
    chk("queue_drained", q.size(), 0);
    chk("hit_pulses", dut_hits, m_total);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
